// File: rtl/sale_terminal_pkg.sv
// Shared constants, price table and enums for the sale-terminal
// selection logic.
package sale_terminal_pkg;

   localparam int GRID_COLS    = 4;
   localparam int GRID_ROWS    = 3;
   localparam int BASKET_DEPTH = 12;
   localparam int PRICE_W      = 16;

   localparam logic [PRICE_W-1:0] PRICE [12] = '{
      16'd5,  16'd10, 16'd15, 16'd20,
      16'd25, 16'd30, 16'd35, 16'd40,
      16'd45, 16'd50, 16'd55, 16'd60
   };

   typedef enum logic {IDLE, COMPACT} state_t;

   typedef enum logic [2:0] {
      A_NONE, A_CLR, A_SEL, A_LEFT, A_RIGHT, A_UP, A_DOWN
   } act_t;

   // Keep the basket cursor inside a list that just shrank to n entries.
   function automatic logic [3:0] fix_b(input logic [3:0] b,
                                        input logic [3:0] n);
      if (n == 4'd0) return 4'd0;
      if (b >= n) return n - 4'd1;
      return b;
   endfunction

endpackage

// File: rtl/basket_store.sv
// Basket register file: one write port, one shift-down port and two
// combinational read ports.
module basket_store
   import sale_terminal_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_en,
   input  logic [3:0] wr_idx,
   input  logic [3:0] wr_data,
   input  logic       shift_en,
   input  logic [3:0] shift_idx,
   input  logic [3:0] rd_idx,
   output logic [3:0] rd_data,
   input  logic [3:0] sel_idx,
   output logic [3:0] sel_data
);

   localparam logic [3:0] LAST = 4'(BASKET_DEPTH - 1);

   logic [3:0] mem [BASKET_DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BASKET_DEPTH; i++) mem[i] <= '0;
      end else if (wr_en && wr_idx <= LAST) begin
         mem[wr_idx] <= wr_data;
      end else if (shift_en && shift_idx < LAST) begin
         mem[shift_idx] <= mem[shift_idx + 4'd1];
      end
   end

   assign rd_data  = (rd_idx <= LAST) ? mem[rd_idx] : '0;
   assign sel_data = (sel_idx <= LAST) ? mem[sel_idx] : '0;

endmodule

// File: rtl/basket_controller.sv
// Sale-terminal selection sequencer: grid cursor, basket list with
// compacting removal, running total and highlight vector.
module basket_controller #(
   parameter int NUM_PRODUCTS = 12,
   parameter int GRID_COLS    = 4,
   parameter int GRID_ROWS    = 3,
   parameter int BASKET_DEPTH = 12,
   parameter int PRICE_WIDTH  = 16
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic                    BTN_Left,
   input  logic                    BTN_Right,
   input  logic                    BTN_Up,
   input  logic                    BTN_Down,
   input  logic                    BTN_Select,
   input  logic                    SW2,
   input  logic                    Clear,
   input  logic [3:0]              BasketRdIdx,
   output logic [3:0]              BasketRdID,
   output logic [NUM_PRODUCTS-1:0] HighlightedProductList,
   output logic [3:0]              BasketProductNum,
   output logic [PRICE_WIDTH-1:0]  TotalPrice,
   output logic                    BasketFull,
   output logic                    Busy
);
   import sale_terminal_pkg::*;

   localparam logic [3:0] COLS  = 4'(GRID_COLS);
   localparam logic [3:0] LASTC = 4'(GRID_COLS - 1);
   localparam logic [3:0] LASTR = 4'(GRID_ROWS - 1);
   localparam logic [3:0] WRAP  = 4'(GRID_COLS * (GRID_ROWS - 1));
   localparam logic [3:0] DEPTH = 4'(BASKET_DEPTH);

   state_t                  state;
   act_t                    act;
   logic [4:0]              btn, btn_d, press;
   logic [3:0]              g, b, k, count;
   logic [3:0]              col, row, g_l, g_r, g_u, g_d, b_dec, b_inc;
   logic [3:0]              rd_id, sel_id;
   logic [PRICE_WIDTH-1:0]  total;
   logic [NUM_PRODUCTS-1:0] hl;
   logic                    sw2_reg, wr_en, shift_en;

   assign btn   = {BTN_Down, BTN_Up, BTN_Right, BTN_Left, BTN_Select};
   assign press = btn & ~btn_d;

   always_comb begin
      act = A_NONE;
      if (state == IDLE) begin
         if (Clear)         act = A_CLR;
         else if (press[0]) act = A_SEL;
         else if (press[1]) act = A_LEFT;
         else if (press[2]) act = A_RIGHT;
         else if (press[3]) act = A_UP;
         else if (press[4]) act = A_DOWN;
      end
   end

   // Row-local wrap for left/right, column-local wrap for up/down.
   assign col   = g % COLS;
   assign row   = g / COLS;
   assign g_l   = (col == 4'd0) ? g + LASTC : g - 4'd1;
   assign g_r   = (col == LASTC) ? g - LASTC : g + 4'd1;
   assign g_u   = (row == 4'd0) ? g + WRAP : g - COLS;
   assign g_d   = (row == LASTR) ? g - WRAP : g + COLS;
   assign b_dec = (b == 4'd0) ? b : b - 4'd1;
   assign b_inc = (b + 4'd1 < count) ? b + 4'd1 : b;

   assign wr_en    = (act == A_SEL) && !SW2 && (count < DEPTH);
   assign shift_en = (state == COMPACT);

   basket_store u_store (
      .clk       (CLK),
      .rst_n     (RST_N),
      .wr_en     (wr_en),
      .wr_idx    (count),
      .wr_data   (g),
      .shift_en  (shift_en),
      .shift_idx (k),
      .rd_idx    (BasketRdIdx),
      .rd_data   (rd_id),
      .sel_idx   (b),
      .sel_data  (sel_id)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state   <= IDLE;
         btn_d   <= '0;
         sw2_reg <= 1'b0;
         g       <= '0;
         b       <= '0;
         k       <= '0;
         count   <= '0;
         total   <= '0;
         hl      <= NUM_PRODUCTS'(1);
      end else begin
         btn_d   <= btn;
         sw2_reg <= SW2;
         if (!sw2_reg)          hl <= NUM_PRODUCTS'(1) << g;
         else if (count != '0)  hl <= NUM_PRODUCTS'(1) << b;
         else                   hl <= '0;
         unique case (state)
            IDLE: begin
               unique case (act)
                  A_NONE: ;
                  A_CLR: begin
                     count <= '0;
                     total <= '0;
                     b     <= '0;
                  end
                  A_SEL: begin
                     if (!SW2) begin
                        if (count < DEPTH) begin
                           count <= count + 4'd1;
                           total <= total + PRICE_WIDTH'(PRICE[g]);
                        end
                     end else if (count != '0) begin
                        total <= total - PRICE_WIDTH'(PRICE[sel_id]);
                        k     <= b;
                        if (b == count - 4'd1) begin
                           count <= count - 4'd1;
                           b     <= fix_b(b, count - 4'd1);
                        end else begin
                           state <= COMPACT;
                        end
                     end
                  end
                  A_LEFT:  if (!SW2) g <= g_l; else b <= b_dec;
                  A_RIGHT: if (!SW2) g <= g_r; else b <= b_inc;
                  A_UP:    if (!SW2) g <= g_u; else b <= b_dec;
                  A_DOWN:  if (!SW2) g <= g_d; else b <= b_inc;
                  default: ;
               endcase
            end
            COMPACT: begin
               k <= k + 4'd1;
               if (k + 4'd1 == count - 4'd1) begin
                  count <= count - 4'd1;
                  b     <= fix_b(b, count - 4'd1);
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign BasketRdID             = (BasketRdIdx < count) ? rd_id : '0;
   assign HighlightedProductList = hl;
   assign BasketProductNum       = count;
   assign TotalPrice             = total;
   assign BasketFull             = (count == DEPTH);
   assign Busy                   = (state == COMPACT);

endmodule

// File: tb/tb_basket_controller.sv
// Directed self-checking bench for basket_controller.
module tb_basket_controller;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        BTN_Left = 1'b0, BTN_Right = 1'b0, BTN_Up = 1'b0;
   logic        BTN_Down = 1'b0, BTN_Select = 1'b0;
   logic        SW2 = 1'b0, Clear = 1'b0;
   logic [3:0]  BasketRdIdx = '0;
   logic [3:0]  BasketRdID;
   logic [11:0] HighlightedProductList;
   logic [3:0]  BasketProductNum;
   logic [15:0] TotalPrice;
   logic        BasketFull, Busy;

   int errors = 0;
   int checks = 0;

   localparam logic [4:0] SEL = 5'b00001;
   localparam logic [4:0] L   = 5'b00010;
   localparam logic [4:0] R   = 5'b00100;
   localparam logic [4:0] U   = 5'b01000;
   localparam logic [4:0] D   = 5'b10000;

   always #5 CLK = ~CLK;

   basket_controller dut (
      .CLK                    (CLK),
      .RST_N                  (RST_N),
      .BTN_Left               (BTN_Left),
      .BTN_Right              (BTN_Right),
      .BTN_Up                 (BTN_Up),
      .BTN_Down               (BTN_Down),
      .BTN_Select             (BTN_Select),
      .SW2                    (SW2),
      .Clear                  (Clear),
      .BasketRdIdx            (BasketRdIdx),
      .BasketRdID             (BasketRdID),
      .HighlightedProductList (HighlightedProductList),
      .BasketProductNum       (BasketProductNum),
      .TotalPrice             (TotalPrice),
      .BasketFull             (BasketFull),
      .Busy                   (Busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic set_btns(input logic [4:0] v);
      {BTN_Down, BTN_Up, BTN_Right, BTN_Left, BTN_Select} = v;
   endtask

   task automatic press(input logic [4:0] v);
      set_btns(v);
      step(1);
      set_btns(5'b0);
      step(1);
   endtask

   task automatic rd(input logic [3:0] idx, input logic [3:0] exp);
      BasketRdIdx = idx;
      #1;
      chk($sformatf("rd%0d", idx), BasketRdID, exp);
   endtask

   initial begin
      step(2);
      chk("rst_hl", HighlightedProductList, 12'h001);
      chk("rst_cnt", BasketProductNum, 0);
      chk("rst_tot", TotalPrice, 0);
      chk("rst_busy", Busy, 0);
      chk("rst_full", BasketFull, 0);
      RST_N = 1'b1;
      step(1);

      press(R); press(R); press(R); press(D);
      chk("g7", HighlightedProductList, 12'h080);
      press(R);
      chk("wrap_r", HighlightedProductList, 12'h010);

      press(U); press(R); press(R);
      chk("g2", HighlightedProductList, 12'h004);
      press(SEL);
      press(D); press(L);
      press(SEL);
      press(D); press(R); press(R);
      chk("g11", HighlightedProductList, 12'h800);
      press(SEL);
      chk("cnt3", BasketProductNum, 3);
      chk("tot105", TotalPrice, 105);
      rd(0, 2); rd(1, 5); rd(2, 11); rd(3, 0);

      SW2 = 1'b1;
      step(2);
      chk("bmode_hl", HighlightedProductList, 12'h001);
      set_btns(SEL);
      step(1);
      chk("busy1", Busy, 1);
      set_btns(5'b0);
      step(1);
      chk("busy2", Busy, 1);
      step(1);
      chk("busy_end", Busy, 0);
      chk("cnt2", BasketProductNum, 2);
      chk("tot90", TotalPrice, 90);
      rd(0, 5); rd(1, 11); rd(2, 0);
      chk("rm_hl", HighlightedProductList, 12'h001);

      press(D);
      chk("b1", HighlightedProductList, 12'h002);
      press(D);
      chk("b_sat_hi", HighlightedProductList, 12'h002);
      press(U); press(U);
      chk("b_sat_lo", HighlightedProductList, 12'h001);
      press(D);
      press(SEL);
      chk("last_busy", Busy, 0);
      chk("last_cnt", BasketProductNum, 1);
      chk("last_tot", TotalPrice, 30);
      chk("last_hl", HighlightedProductList, 12'h001);

      Clear = 1'b1;
      step(1);
      Clear = 1'b0;
      step(1);
      chk("clr_cnt", BasketProductNum, 0);
      chk("clr_tot", TotalPrice, 0);
      chk("empty_hl", HighlightedProductList, 12'h000);
      press(SEL);
      chk("empty_sel", BasketProductNum, 0);
      chk("empty_busy", Busy, 0);

      SW2 = 1'b0;
      repeat (11) press(SEL);
      chk("full11", BasketFull, 0);
      press(SEL);
      chk("full_cnt", BasketProductNum, 12);
      chk("full_flag", BasketFull, 1);
      chk("full_tot", TotalPrice, 720);
      press(SEL);
      chk("over_cnt", BasketProductNum, 12);
      chk("over_tot", TotalPrice, 720);
      rd(11, 11);

      Clear = 1'b1;
      step(1);
      Clear = 1'b0;
      step(1);
      press(SEL | L);
      chk("prio_cnt", BasketProductNum, 1);
      chk("prio_tot", TotalPrice, 60);
      chk("prio_g", HighlightedProductList, 12'h800);
      set_btns(SEL);
      step(5);
      set_btns(5'b0);
      step(1);
      chk("hold_cnt", BasketProductNum, 2);
      chk("hold_tot", TotalPrice, 120);

      press(SEL);
      chk("cnt3b", BasketProductNum, 3);
      SW2 = 1'b1;
      step(2);
      set_btns(SEL);
      step(1);
      chk("cbusy", Busy, 1);
      set_btns(5'b0);
      Clear = 1'b1;
      step(1);
      Clear = 1'b0;
      step(1);
      chk("cclr_busy", Busy, 0);
      chk("cclr_cnt", BasketProductNum, 2);
      chk("cclr_tot", TotalPrice, 120);
      rd(0, 11);

      set_btns(SEL);
      step(1);
      chk("rbusy", Busy, 1);
      RST_N = 1'b0;
      #1;
      chk("rcnt", BasketProductNum, 0);
      chk("rbusy0", Busy, 0);
      chk("rhl", HighlightedProductList, 12'h001);
      chk("rtot", TotalPrice, 0);
      set_btns(5'b0);
      step(1);
      RST_N = 1'b1;
      step(1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
